// File: rtl/booth_multiplier_if.sv
// Operand/result bundle for booth_multiplier; done exists only when
// BOOTH_DONE_PULSE_EN is defined.
interface booth_multiplier_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               start;
    logic               busy;
    logic [2*WIDTH-1:0] ab;
`ifdef BOOTH_DONE_PULSE_EN
    logic               done;
`endif

`ifdef BOOTH_DONE_PULSE_EN
    modport master (output a, b, start, input busy, ab, done);
    modport slave  (input a, b, start, output busy, ab, done);
`else
    modport master (output a, b, start, input busy, ab);
    modport slave  (input a, b, start, output busy, ab);
`endif
endinterface

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier, one step per clock.
// Optional one-cycle completion pulse on bus.done with BOOTH_DONE_PULSE_EN.
module booth_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    booth_multiplier_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] ab_q, ab_d;
    logic               done_q, done_d;
    logic [WIDTH:0]     sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            ab_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            ab_q    <= ab_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        count_d = count_q;
        ab_d    = ab_q;
        done_d  = 1'b0;
        sum     = acc_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = {bus.a[WIDTH-1], bus.a};
                    acc_d   = '0;
                    q_d     = bus.b;
                    q1_d    = 1'b0;
                    count_d = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                case ({q_q[0], q1_q})
                    2'b01:   sum = acc_q + m_q;
                    2'b10:   sum = acc_q - m_q;
                    default: sum = acc_q;
                endcase
                // Arithmetic right shift of {sum, Q, q_1} with the sign replicated.
                acc_d   = {sum[WIDTH], sum[WIDTH:1]};
                q_d     = {sum[0], q_q[WIDTH-1:1]};
                q1_d    = q_q[0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    ab_d    = {acc_d[WIDTH-1:0], q_d};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ab   = ab_q;
    assign bus.busy = (state_q == RUN);

`ifdef BOOTH_DONE_PULSE_EN
    assign bus.done = done_q;
`else
    logic unused_done;
    assign unused_done = done_q;
`endif
endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: table vectors, random operands
// against a plain-arithmetic model, and hand-written protocol sequences.
module tb_booth_multiplier;
    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    booth_multiplier_if #(.WIDTH(8)) bus ();

    booth_multiplier #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0]  a;
        logic signed [7:0]  b;
        logic signed [15:0] prod;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
                     name, $signed(actual), actual, $signed(expected), expected);
        end
    endtask

    // Drives one operation; start stays high for hold negedges. inject=1
    // presents a fresh start with junk operands partway through the run.
    task automatic applyStimulus(input logic signed [7:0] ia, input logic signed [7:0] ib,
                                 input int hold, input bit inject,
                                 input logic signed [15:0] expAb, input string name);
        logic [15:0] prevAb;
        int          cycles;
        int          holdLeft;
        bit          abMoved;
        bit          doneEarly;
        prevAb    = bus.ab;
        abMoved   = 1'b0;
        doneEarly = 1'b0;
        bus.a     = ia;
        bus.b     = ib;
        bus.start = 1'b1;
        holdLeft  = hold;
        cycles    = 0;
        @(negedge clk);
        holdLeft--;
        if (holdLeft == 0) bus.start = 1'b0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            if (bus.ab !== prevAb) abMoved = 1'b1;
`ifdef BOOTH_DONE_PULSE_EN
            if (bus.done !== 1'b0) doneEarly = 1'b1;
`endif
            if (inject && cycles == 3) begin
                bus.a     = 8'sd99;
                bus.b     = -8'sd3;
                bus.start = 1'b1;
            end
            if (inject && cycles == 5) bus.start = 1'b0;
            @(negedge clk);
            holdLeft--;
            if (holdLeft == 0) bus.start = 1'b0;
        end
        checkOutput({name, " busy cycles"}, 16'(cycles), 16'd8);
        checkOutput({name, " ab stable during run"}, 16'(abMoved), 16'd0);
        checkOutput({name, " product"}, bus.ab, expAb);
`ifdef BOOTH_DONE_PULSE_EN
        checkOutput({name, " done early"}, 16'(doneEarly), 16'd0);
        checkOutput({name, " done at completion"}, 16'(bus.done), 16'd1);
`endif
    endtask

    task automatic checkIdle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput({name, " busy idle"}, 16'(bus.busy), 16'd0);
`ifdef BOOTH_DONE_PULSE_EN
            checkOutput({name, " done idle"}, 16'(bus.done), 16'd0);
`endif
        end
    endtask

    initial begin
        logic signed [7:0]  ra;
        logic signed [7:0]  rb;
        logic signed [15:0] model;
        int                 cycles;
        assertCount = 0;
        failCount   = 0;

        vecs[0] = '{a: 8'sd3,    b: 8'sd17,   prod: 16'sd51};
        vecs[1] = '{a: 8'sd7,    b: 8'sd7,    prod: 16'sd49};
        vecs[2] = '{a: -8'sd5,   b: 8'sd6,    prod: -16'sd30};
        vecs[3] = '{a: -8'sd128, b: -8'sd128, prod: 16'sd16384};
        vecs[4] = '{a: -8'sd128, b: 8'sd127,  prod: -16'sd16256};
        vecs[5] = '{a: 8'sd0,    b: -8'sd1,   prod: 16'sd0};
        vecs[6] = '{a: 8'sd127,  b: 8'sd127,  prod: 16'sd16129};
        vecs[7] = '{a: -8'sd1,   b: -8'sd1,   prod: 16'sd1};
        vecs[8] = '{a: 8'sd127,  b: -8'sd128, prod: -16'sd16256};
        vecs[9] = '{a: 8'sd85,   b: -8'sd86,  prod: -16'sd7310};

        reset     = 1'b1;
        bus.a     = '0;
        bus.b     = '0;
        bus.start = 1'b0;
        #1;
        checkOutput("reset ab", bus.ab, 16'd0);
        checkOutput("reset busy", 16'(bus.busy), 16'd0);
`ifdef BOOTH_DONE_PULSE_EN
        checkOutput("reset done", 16'(bus.done), 16'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] basic 3*17 with start held 5 cycles");
        applyStimulus(8'sd3, 8'sd17, 5, 1'b0, 16'sd51, "basic");
        checkIdle("after basic", 3);

        $display("[TB] back-to-back 7*7");
        applyStimulus(8'sd7, 8'sd7, 5, 1'b0, 16'sd49, "b2b");

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1, 1'b0, vecs[i].prod, $sformatf("vec%0d", i));
        end

        $display("[TB] start during busy is ignored");
        applyStimulus(-8'sd5, 8'sd6, 1, 1'b1, -16'sd30, "inject");
        checkIdle("after inject", 2);

        $display("[TB] start held across completion restarts with current operands");
        applyStimulus(8'sd2, 8'sd3, 10, 1'b0, 16'sd6, "restart");
        bus.a = 8'sd4;
        bus.b = 8'sd5;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("restart busy again", 16'(bus.busy), 16'd1);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("restart second busy cycles", 16'(cycles), 16'd8);
        checkOutput("restart second product", bus.ab, 16'sd20);

        $display("[TB] async reset mid-run");
        bus.a     = 8'sd9;
        bus.b     = 8'sd9;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre-reset busy", 16'(bus.busy), 16'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset ab", bus.ab, 16'd0);
        checkOutput("async reset busy", 16'(bus.busy), 16'd0);
`ifdef BOOTH_DONE_PULSE_EN
        checkOutput("async reset done", 16'(bus.done), 16'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'sd3, 8'sd17, 1, 1'b0, 16'sd51, "post-reset");

        $display("[TB] random operands against model");
        for (int i = 0; i < 25; i++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            model = ra * rb;
            applyStimulus(ra, rb, 1, 1'b0, model, $sformatf("rand%0d %0d*%0d", i, ra, rb));
        end

        checkIdle("final", 2);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
